// File: rtl/vend_txn_if.sv
// Bundles the front-end, price-table, dispenser and hopper signals of the vending transaction controller.
// The master modport is the controller side; slave is the surrounding datapath.
interface vend_txn_if #(
  parameter int ITEM_W = 6,
  parameter int AMT_W  = 16
);
  logic              note_valid;
  logic [AMT_W-1:0]  note_val;
  logic              note_accept;
  logic              sel_valid;
  logic [ITEM_W-1:0] sel_code;
  logic              cancel;
  logic              price_rd;
  logic [ITEM_W-1:0] price_addr;
  logic [AMT_W-1:0]  price_data;
  logic              disp_req;
  logic [ITEM_W-1:0] disp_code;
  logic              disp_ack;
  logic              chg_valid;
  logic [AMT_W-1:0]  chg_amt;
  logic              chg_ready;
  logic [AMT_W-1:0]  credit;
  logic              busy;
  logic              err_insufficient;
  logic              err_unavail;

  modport master (
    input  note_valid, note_val, sel_valid, sel_code, cancel,
           price_data, disp_ack, chg_ready,
    output note_accept, price_rd, price_addr, disp_req, disp_code,
           chg_valid, chg_amt, credit, busy, err_insufficient, err_unavail
  );

  modport slave (
    output note_valid, note_val, sel_valid, sel_code, cancel,
           price_data, disp_ack, chg_ready,
    input  note_accept, price_rd, price_addr, disp_req, disp_code,
           chg_valid, chg_amt, credit, busy, err_insufficient, err_unavail
  );
endinterface

// File: rtl/vend_txn_ctrl.sv
// Customer transaction sequencer: collects credit, looks up the price, dispenses and pays change.
// Two-process FSM; error pulses are registered so they coincide with the return to COLLECT.
module vend_txn_ctrl #(
  parameter int ITEM_W  = 6,
  parameter int AMT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input logic        clk,
  input logic        rstn,
  vend_txn_if.master bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, COLLECT, LOOKUP, CHECK, DISPENSE, PAYOUT} state_t;

  state_t            state, state_nx;
  logic [AMT_W-1:0]  credit_q, credit_nx;
  logic [ITEM_W-1:0] code_q, code_nx;
  logic [CNT_W-1:0]  idle_cnt, idle_cnt_nx;
  logic              err_ins_q, err_ins_nx;
  logic              err_un_q, err_un_nx;
  logic [AMT_W:0]    note_sum;
  logic              note_fits;
  logic              note_ok;

  // One extra bit catches notes that would wrap the credit register.
  assign note_sum  = {1'b0, credit_q} + {1'b0, bus.note_val};
  assign note_fits = ~note_sum[AMT_W];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      credit_q  <= '0;
      code_q    <= '0;
      idle_cnt  <= '0;
      err_ins_q <= 1'b0;
      err_un_q  <= 1'b0;
    end else begin
      state     <= state_nx;
      credit_q  <= credit_nx;
      code_q    <= code_nx;
      idle_cnt  <= idle_cnt_nx;
      err_ins_q <= err_ins_nx;
      err_un_q  <= err_un_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    credit_nx   = credit_q;
    code_nx     = code_q;
    idle_cnt_nx = '0;
    err_ins_nx  = 1'b0;
    err_un_nx   = 1'b0;
    note_ok     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.note_valid && note_fits) begin
          note_ok   = 1'b1;
          credit_nx = bus.note_val;
          state_nx  = COLLECT;
        end
      end
      COLLECT: begin
        // Cancel wins over both a note and a selection in the same cycle.
        if (bus.cancel) begin
          state_nx = PAYOUT;
        end else begin
          if (bus.note_valid && note_fits) begin
            note_ok   = 1'b1;
            credit_nx = note_sum[AMT_W-1:0];
          end
          if (bus.sel_valid) begin
            code_nx  = bus.sel_code;
            state_nx = LOOKUP;
          end else if (!bus.note_valid && idle_cnt == CNT_W'(TIMEOUT - 1)) begin
            state_nx = PAYOUT;
          end
          if (!bus.note_valid && !bus.sel_valid) idle_cnt_nx = idle_cnt + CNT_W'(1);
        end
      end
      LOOKUP: state_nx = CHECK;
      CHECK: begin
        if (bus.price_data == '0) begin
          err_un_nx = 1'b1;
          state_nx  = COLLECT;
        end else if (credit_q < bus.price_data) begin
          err_ins_nx = 1'b1;
          state_nx   = COLLECT;
        end else begin
          credit_nx = credit_q - bus.price_data;
          state_nx  = DISPENSE;
        end
      end
      DISPENSE: begin
        if (bus.disp_ack) state_nx = (credit_q != '0) ? PAYOUT : IDLE;
      end
      PAYOUT: begin
        if (bus.chg_ready) begin
          credit_nx = '0;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.note_accept      = note_ok & rstn;
  assign bus.price_rd         = (state == LOOKUP);
  assign bus.price_addr       = bus.price_rd ? code_q : '0;
  assign bus.disp_req         = (state == DISPENSE);
  assign bus.disp_code        = bus.disp_req ? code_q : '0;
  assign bus.chg_valid        = (state == PAYOUT);
  assign bus.chg_amt          = bus.chg_valid ? credit_q : '0;
  assign bus.credit           = credit_q;
  assign bus.busy             = (state != IDLE);
  assign bus.err_insufficient = err_ins_q;
  assign bus.err_unavail      = err_un_q;
endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Directed bench for vend_txn_ctrl with a price-table model and dispense/payout scoreboards.
`timescale 1ns/1ps
module tb_vend_txn_ctrl;
  localparam int ITEM_W  = 6;
  localparam int AMT_W   = 16;
  localparam int TIMEOUT = 20;

  logic clk = 1'b0;
  logic rstn;
  int   tests = 0;
  int   fails = 0;

  logic [AMT_W-1:0]  price_mem [64];
  logic [ITEM_W-1:0] exp_disp[$];
  logic [AMT_W-1:0]  exp_chg[$];

  vend_txn_if #(.ITEM_W(ITEM_W), .AMT_W(AMT_W)) bus ();

  vend_txn_ctrl #(.ITEM_W(ITEM_W), .AMT_W(AMT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Price table: registered one-cycle read port.
  always @(posedge clk) bus.price_data <= bus.price_rd ? price_mem[bus.price_addr] : '0;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_note(input logic [AMT_W-1:0] v, input logic exp_acc);
    bus.note_valid = 1'b1;
    bus.note_val   = v;
    #1;
    check_output("note_accept", bus.note_accept, exp_acc);
    @(negedge clk);
    bus.note_valid = 1'b0;
    bus.note_val   = '0;
  endtask

  task automatic apply_stimulus(input logic [ITEM_W-1:0] code);
    bus.sel_valid = 1'b1;
    bus.sel_code  = code;
    @(negedge clk);
    bus.sel_valid = 1'b0;
    check_output("price_rd", bus.price_rd, 1);
    check_output("price_addr", bus.price_addr, code);
  endtask

  task automatic wait_disp(input int exp_lat);
    int n = 0;
    logic [ITEM_W-1:0] code = '1;
    while (!bus.disp_req && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_output("disp_req_seen", bus.disp_req, 1);
    check_output("disp_latency", n, exp_lat);
    if (exp_disp.size() > 0) code = exp_disp.pop_front();
    check_output("disp_code", bus.disp_code, code);
  endtask

  task automatic wait_chg(input int exp_lat);
    int n = 0;
    logic [AMT_W-1:0] amt = '1;
    while (!bus.chg_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_output("chg_valid_seen", bus.chg_valid, 1);
    check_output("chg_latency", n, exp_lat);
    if (exp_chg.size() > 0) amt = exp_chg.pop_front();
    check_output("chg_amt", bus.chg_amt, amt);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) price_mem[i] = 16'd100;
    price_mem[5] = 16'd25;
    price_mem[7] = 16'd50;
    price_mem[9] = 16'd0;
    price_mem[3] = 16'd40;
    bus.note_valid = 1'b0;
    bus.note_val   = '0;
    bus.sel_valid  = 1'b0;
    bus.sel_code   = '0;
    bus.cancel     = 1'b0;
    bus.disp_ack   = 1'b1;
    bus.chg_ready  = 1'b1;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_credit", bus.credit, 0);
    check_output("rst_busy", bus.busy, 0);
    check_output("rst_disp_req", bus.disp_req, 0);
    check_output("rst_chg_valid", bus.chg_valid, 0);
    check_output("rst_price_rd", bus.price_rd, 0);
    check_output("rst_err_ins", bus.err_insufficient, 0);
    rstn = 1'b1;
    @(negedge clk);

    // 10 + 20, item 5 at 25: dispense at +3, change 5.
    send_note(16'd10, 1'b1);
    check_output("credit_10", bus.credit, 10);
    check_output("busy_collect", bus.busy, 1);
    send_note(16'd20, 1'b1);
    check_output("credit_30", bus.credit, 30);
    exp_disp.push_back(6'd5);
    exp_chg.push_back(16'd5);
    apply_stimulus(6'd5);
    wait_disp(2);
    check_output("credit_after_price", bus.credit, 5);
    wait_chg(1);
    @(negedge clk);
    check_output("idle_busy_t1", bus.busy, 0);
    check_output("idle_credit_t1", bus.credit, 0);

    // Insufficient credit, then top up and retry.
    send_note(16'd20, 1'b1);
    apply_stimulus(6'd7);
    @(negedge clk);
    @(negedge clk);
    check_output("err_ins_pulse", bus.err_insufficient, 1);
    check_output("err_ins_credit", bus.credit, 20);
    check_output("err_ins_no_disp", bus.disp_req, 0);
    @(negedge clk);
    check_output("err_ins_one_cycle", bus.err_insufficient, 0);
    check_output("err_ins_busy", bus.busy, 1);
    send_note(16'd50, 1'b1);
    check_output("credit_70", bus.credit, 70);
    exp_disp.push_back(6'd7);
    exp_chg.push_back(16'd20);
    apply_stimulus(6'd7);
    wait_disp(2);
    wait_chg(1);
    @(negedge clk);

    // Unavailable item, then cancel refunds everything.
    send_note(16'd30, 1'b1);
    apply_stimulus(6'd9);
    @(negedge clk);
    @(negedge clk);
    check_output("err_un_pulse", bus.err_unavail, 1);
    check_output("err_un_credit", bus.credit, 30);
    check_output("err_un_no_disp", bus.disp_req, 0);
    @(negedge clk);
    check_output("err_un_one_cycle", bus.err_unavail, 0);
    exp_chg.push_back(16'd30);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    wait_chg(0);
    @(negedge clk);
    check_output("idle_after_cancel", bus.busy, 0);

    // Exact payment with a slow dispenser: no change afterwards.
    bus.disp_ack = 1'b0;
    send_note(16'd40, 1'b1);
    exp_disp.push_back(6'd3);
    apply_stimulus(6'd3);
    wait_disp(2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_output("disp_req_hold", bus.disp_req, 1);
      check_output("disp_code_hold", bus.disp_code, 3);
    end
    bus.disp_ack = 1'b1;
    @(negedge clk);
    check_output("exact_idle", bus.busy, 0);
    check_output("exact_no_chg", bus.chg_valid, 0);

    // Overflowing note rejected; note with cancel rejected.
    send_note(16'd65530, 1'b1);
    send_note(16'd10, 1'b0);
    check_output("overflow_credit", bus.credit, 65530);
    exp_chg.push_back(16'd65530);
    bus.note_valid = 1'b1;
    bus.note_val   = 16'd5;
    bus.cancel     = 1'b1;
    #1;
    check_output("note_cancel_reject", bus.note_accept, 0);
    @(negedge clk);
    bus.note_valid = 1'b0;
    bus.cancel     = 1'b0;
    wait_chg(0);
    @(negedge clk);

    // Idle timeout refunds the credit.
    send_note(16'd10, 1'b1);
    exp_chg.push_back(16'd10);
    wait_chg(TIMEOUT);
    @(negedge clk);
    check_output("idle_after_timeout", bus.busy, 0);

    // Asynchronous reset in the middle of a dispense.
    bus.disp_ack = 1'b0;
    send_note(16'd40, 1'b1);
    exp_disp.push_back(6'd3);
    apply_stimulus(6'd3);
    wait_disp(2);
    #2;
    rstn = 1'b0;
    #1;
    check_output("mid_rst_disp_req", bus.disp_req, 0);
    check_output("mid_rst_disp_code", bus.disp_code, 0);
    check_output("mid_rst_credit", bus.credit, 0);
    check_output("mid_rst_busy", bus.busy, 0);
    check_output("mid_rst_chg_valid", bus.chg_valid, 0);
    @(negedge clk);
    rstn = 1'b1;
    bus.disp_ack = 1'b1;
    repeat (2) @(negedge clk);
    check_output("post_rst_no_chg", bus.chg_valid, 0);
    check_output("post_rst_idle", bus.busy, 0);

    check_output("sb_disp_left", exp_disp.size(), 0);
    check_output("sb_chg_left", exp_chg.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vend_txn_ctrl.md
# vend_txn_ctrl

Transaction sequencer for the vending machine datapath. Accumulates inserted notes into a credit register and looks up the selected item's price from the configuration price table over a one-cycle read port. It then runs the dispense handshake and returns change through a change-payout handshake. Sits between the note/selection front-end and the price table, dispenser motor and change hopper, and owns the whole customer transaction.

## Interface
Parameters:
- ITEM_W, 6, item code width (64 price-table entries)
- AMT_W, 16, credit/price/change width in rupees
- TIMEOUT, 1000, idle cycles in COLLECT before automatic refund

Ports:
- clk  in  1  single clock; all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- note_valid  in  1  one-cycle note-inserted strobe
- note_val  in  AMT_W  note value, qualified by note_valid
- note_accept  out  1  combinational; note taken this cycle
- sel_valid  in  1  one-cycle item-selection strobe
- sel_code  in  ITEM_W  selected item
- cancel  in  1  one-cycle refund request
- price_rd  out  1  price-table read strobe
- price_addr  out  ITEM_W  price-table address
- price_data  in  AMT_W  price, valid the cycle after price_rd; 0 means unavailable
- disp_req  out  1  dispense request, held until ack
- disp_code  out  ITEM_W  item to dispense, stable while disp_req
- disp_ack  in  1  dispenser done
- chg_valid  out  1  change/refund payout request, held until ready
- chg_amt  out  AMT_W  payout amount, stable while chg_valid
- chg_ready  in  1  hopper accepted payout
- credit  out  AMT_W  current credit
- busy  out  1  state != IDLE
- err_insufficient  out  1  one-cycle pulse, credit < price
- err_unavail  out  1  one-cycle pulse, price == 0

## Operation
- States: IDLE, COLLECT, LOOKUP, CHECK, DISPENSE, PAYOUT.
- note_accept = note_valid & state in {IDLE, COLLECT} & (credit + note_val) does not exceed 2^AMT_W-1 (sum computed AMT_W+1 wide). An overflowing note is rejected and credit is unchanged. Notes in any other state are rejected.
- IDLE: credit == 0. An accepted note sets credit = note_val and moves to COLLECT. sel_valid and cancel are ignored in IDLE.
- COLLECT:
  - An accepted note adds note_val to credit.
  - cancel moves to PAYOUT. If a note and cancel arrive in the same cycle, the note is rejected.
  - sel_valid without cancel latches sel_code, moves to LOOKUP, and drives price_rd=1 and price_addr=sel_code in LOOKUP. A note arriving in the same cycle is still added.
  - Idle counter resets on any note_valid or sel_valid. When it reaches TIMEOUT, moves to PAYOUT.
- LOOKUP: one cycle with price_rd high, then CHECK.
- CHECK: samples price_data.
  - price == 0: pulse err_unavail, return to COLLECT with credit kept.
  - credit < price: pulse err_insufficient, return to COLLECT.
  - Otherwise: credit -= price, go to DISPENSE.
  - In every case the idle counter is cleared.
- DISPENSE: disp_req=1 and disp_code=latched code. On disp_req & disp_ack, go to PAYOUT if credit > 0, else IDLE.
- PAYOUT: chg_valid=1 and chg_amt=credit. On chg_valid & chg_ready, credit=0 and go to IDLE.
- cancel is ignored outside COLLECT.

## Timing
- Reset values: every output 0, state IDLE, credit 0, latched code 0, idle counter 0.
- Reset mid-transaction drops all credit with no payout and aborts disp_req/chg_valid immediately.
- An accepted note is visible on credit the cycle after note_valid.
- Selection to disp_req, price sufficient: sel_valid at cycle N, price_rd at N+1, compare at N+2, disp_req high at N+3.
- Error pulses assert for exactly the cycle after CHECK, coincident with the return to COLLECT.
- Handshakes:
  - disp_ack and chg_ready may be tied high. Minimum dwell in DISPENSE and in PAYOUT is 1 cycle.
  - Acks are ignored when the corresponding request is low.
- Timeout: with no activity, PAYOUT is entered TIMEOUT cycles after the last note/selection.

## Test plan
- Reset, insert 10 then 20, select item 5 with price 25: credit 30, disp_req at +3 with disp_code 5, after ack chg_amt=5, then IDLE with credit 0.
- Insert 20, select price 50: err_insufficient pulse, stays in COLLECT with credit 20. Insert 50, reselect: dispense, change 20.
- Select item with price 0: err_unavail, no disp_req, credit kept. Then cancel: chg_valid with chg_amt equal to full credit.
- Exact payment 40/40: dispense, then straight to IDLE with no chg_valid. Hold disp_ack low 10 cycles: disp_req/disp_code stay stable throughout.
- Credit 65530, note 10: note_accept=0, credit unchanged. Note and cancel in the same cycle: note rejected, refund of prior credit.
- Insert 10, wait TIMEOUT cycles: refund of 10. Then assert rstn low during DISPENSE: all outputs 0 asynchronously, state IDLE.
